hazard_stream_checker: RTL
==========================

# hazard_stream_checker

Streaming RAW-hazard detector for the 8-bit 5-stage RISC pipeline, generalised in register-field width and look-back depth. It accepts one instruction per cycle in program order over a valid/ready handshake. Each instruction is compared against a sliding window of the last DEPTH accepted instructions. Each detected dependency is emitted as a hazard record into an internal FIFO drained by a valid/ready consumer, such as a stall/forward planner or a bench scoreboard.

## Interface
- REG_W, 3: register-field width; INSTR_W = 2 + 2*REG_W (8 at default)
- DEPTH, 2: look-back window in instructions, 1..8
- SEQ_W, 8: sequence-number width, wraps modulo 2^SEQ_W
- FIFO_DEPTH, 4: record FIFO entries, power of 2, at least 2
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  instruction offered
- in_ready  out  1  instruction accepted when in_valid && in_ready
- in_instr  in  INSTR_W  fields: opc [INSTR_W-1:INSTR_W-2], ra [2*REG_W-1:REG_W], rb [REG_W-1:0]
- flush  in  1  clear window (branch redirect)
- rec_valid  out  1  record available
- rec_ready  in  1  consumer takes record
- rec_data  out  2*SEQ_W+2  {prod_seq, cons_seq, kind[1:0]}
- hazard_cnt  out  16  saturating count of records written

## Operation
- Opcodes:
  - noop 00: no sources, no dest
  - add 01: dest ra; sources ra, rb
  - sw 10: sources ra (data), rb (address); no dest
  - lw 11: dest ra; source rb
- Register 0 is hardwired zero. It never produces and never consumes a hazard.
- Window entry: {valid, has_dest, dest, is_load, seq}. On accept, the new entry shifts in at distance 1, the oldest drops out, and seq_cnt increments with wrap.
- Per source, find the nearest valid window entry (smallest distance d) with has_dest and dest equal to the source. Younger writers shadow older ones.
- kind is 10 (LOAD_USE) if the producer is_load and d == 1, otherwise 01 (RAW).
- Records written in the accept cycle:
  - ra-source record first, then rb-source record.
  - Up to 2 records per instruction.
  - If both sources resolve to the same producer (including ra == rb), only one record is written.
- in_ready = (FIFO free slots >= 2), a combinational function of registered FIFO state.
- The FIFO accepts 0, 1 or 2 writes and 1 read per cycle. Push and pop in the same cycle are allowed.
- flush clears all window valid bits; seq_cnt is unaffected.
  - If flush and an accept occur in the same cycle, the incoming instruction is checked against an empty window (no records).
  - That instruction then becomes the sole valid entry.
- hazard_cnt adds 0/1/2 per accept and saturates at 16'hFFFF.

## Timing
- Reset values:
  - in_ready = 1, rec_valid = 0, rec_data = 0, hazard_cnt = 0
  - window invalid, seq_cnt = 0, FIFO empty
- Latency: a record written on accept edge N is visible on rec_valid/rec_data after edge N; at the earliest it is consumed at edge N+1.
- rec_data is held stable while rec_valid && !rec_ready.
- in_ready may only fall through FIFO occupancy; it never depends on in_valid.
- Reset mid-operation: window, FIFO contents and counters are discarded immediately (asynchronous).
- seq wrap: record seq values are raw modulo values. The consumer computes distance as (cons - prod) mod 2^SEQ_W.

## Configuration
- HDU_FWD_EN defined: forwarding-aware mode.
  - Only LOAD_USE (kind 10) records are written; RAW records are suppressed as forwardable.
  - hazard_cnt counts only written records.
- HDU_FWD_EN undefined: every RAW dependency within DEPTH is reported with the kind rule above.

## Structure
- Package hdu_pkg holds:
  - opcode constants (OPC_NOOP/ADD/SW/LW)
  - kind constants (KIND_RAW = 01, KIND_LOAD_USE = 10)
  - the window-entry struct, parametrised through localparam widths
- Sub-module hdu_rec_fifo: 2-write/1-read synchronous FIFO with a free-count output, same clk/rst_n.

## Test plan
- Load-use: lw r1,(r2) 0xCA then add r3,r1 0x59 -> one record {8'd0, 8'd1, 2'b10}; hazard_cnt = 1 (same result in both configurations).
- Distance 2: add r1,r2 0x4A, noop 0x00, add r4,r1 0x61 -> record {0, 2, 01}. With HDU_FWD_EN: no record and hazard_cnt = 0.
- Dual source: add r1,r2 0x4A, lw r3,(r4) 0xDC, sw r1,(r3) 0x8B -> records {0,2,01} then {1,2,10} on consecutive rec beats.
- Boundaries:
  - add r0,r1 0x41 then add r2,r0 0x50 -> no record.
  - With DEPTH = 2, a producer at distance 3 -> no record.
  - A shadowed older writer is never reported.
- Flush: lw r1 0xCA, flush pulse, add r3,r1 0x59 -> no record. A same-cycle flush+accept also yields no record.
- Backpressure: FIFO_DEPTH = 4, rec_ready = 0, stream 0xCA/0x59 pairs -> in_ready drops once free < 2. Raising rec_ready drains records in order with no loss or duplication; in_ready then reasserts.

Source files
------------

// File: rtl/hdu_pkg.sv
// Shared opcode/kind encodings and window-entry layout for the RAW-hazard stream checker.
// Optional feature macro: HDU_FWD_EN (see hazard_stream_checker.sv).
package hdu_pkg;

   localparam logic [1:0] OPC_NOOP = 2'b00;
   localparam logic [1:0] OPC_ADD  = 2'b01;
   localparam logic [1:0] OPC_SW   = 2'b10;
   localparam logic [1:0] OPC_LW   = 2'b11;

   localparam logic [1:0] KIND_RAW      = 2'b01;
   localparam logic [1:0] KIND_LOAD_USE = 2'b10;

   // Entry layout at the default field widths; the top re-declares it at its parameter widths.
   localparam int unsigned ENT_REG_W = 3;
   localparam int unsigned ENT_SEQ_W = 8;

   typedef struct packed {
      logic                 valid;
      logic                 has_dest;
      logic [ENT_REG_W-1:0] dest;
      logic                 is_load;
      logic [ENT_SEQ_W-1:0] seq;
   } hdu_entry_t;

   function automatic logic opc_writes(input logic [1:0] opc);
      return (opc == OPC_ADD) || (opc == OPC_LW);
   endfunction

endpackage

// File: rtl/hdu_rec_fifo.sv
// Hazard-record FIFO: up to two writes and one read per cycle, exposes free-slot count.
// Writers must only push when free >= number of writes; wr1 is only used together with wr0.
module hdu_rec_fifo #(
   parameter int unsigned WIDTH = 18,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     wr0_en,
   input  logic [WIDTH-1:0]         wr0_data,
   input  logic                     wr1_en,
   input  logic [WIDTH-1:0]         wr1_data,
   input  logic                     rd_en,
   output logic                     rd_valid,
   output logic [WIDTH-1:0]         rd_data,
   output logic [$clog2(DEPTH):0]   free
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wptr_q, rptr_q;
   logic [AW:0]      count_q;
   logic [AW:0]      n_wr;
   logic             pop;

   assign n_wr     = (AW+1)'(wr0_en) + (AW+1)'(wr1_en);
   assign rd_valid = (count_q != '0);
   assign pop      = rd_en && rd_valid;
   assign rd_data  = rd_valid ? mem_q[rptr_q] : '0;
   assign free     = (AW+1)'(DEPTH) - count_q;

   always_ff @(posedge clk) begin
      if (wr0_en) mem_q[wptr_q] <= wr0_data;
      if (wr1_en) mem_q[wptr_q + AW'(1)] <= wr1_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_q + n_wr[AW-1:0];
         if (pop) rptr_q <= rptr_q + AW'(1);
         count_q <= count_q + n_wr - (AW+1)'(pop);
      end
   end

endmodule

// File: rtl/hazard_stream_checker.sv
// Streaming RAW-hazard detector over a sliding window of the last DEPTH accepted instructions.
// Define HDU_FWD_EN for forwarding-aware mode: only load-use records are written.
module hazard_stream_checker
   import hdu_pkg::*;
#(
   parameter int unsigned REG_W      = 3,
   parameter int unsigned DEPTH      = 2,
   parameter int unsigned SEQ_W      = 8,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [2*REG_W+1:0]   in_instr,
   input  logic                 flush,
   output logic                 rec_valid,
   input  logic                 rec_ready,
   output logic [2*SEQ_W+1:0]   rec_data,
   output logic [15:0]          hazard_cnt
);

   localparam int unsigned INSTR_W = 2 + 2*REG_W;
   localparam int unsigned REC_W   = 2*SEQ_W + 2;
   localparam int unsigned IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned FREE_W  = $clog2(FIFO_DEPTH) + 1;

   typedef struct packed {
      logic             valid;
      logic             has_dest;
      logic [REG_W-1:0] dest;
      logic             is_load;
      logic [SEQ_W-1:0] seq;
   } entry_t;

   entry_t           win_q [DEPTH];
   logic [SEQ_W-1:0] seq_cnt_q;
   logic [15:0]      cnt_q, cnt_d;

   logic [1:0]       opc;
   logic [REG_W-1:0] ra, rb;
   logic             accept;
   logic             hit_a, hit_b, use_a, use_b, keep_a, keep_b, en_a, en_b;
   logic [IDX_W-1:0] idx_a, idx_b;
   logic [1:0]       kind_a, kind_b;
   logic [REC_W-1:0] rec_a, rec_b;
   logic             wr0_en, wr1_en;
   logic [FREE_W-1:0] free;
   logic [16:0]      cnt_sum;
   entry_t           new_entry;

   assign opc    = in_instr[INSTR_W-1:INSTR_W-2];
   assign ra     = in_instr[2*REG_W-1:REG_W];
   assign rb     = in_instr[REG_W-1:0];
   assign accept = in_valid && in_ready;

   // Scan oldest to youngest so the nearest matching writer wins.
   always_comb begin
      hit_a = 1'b0;
      idx_a = '0;
      hit_b = 1'b0;
      idx_b = '0;
      for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
         if (win_q[i].valid && win_q[i].has_dest && win_q[i].dest == ra) begin
            hit_a = 1'b1;
            idx_a = IDX_W'(i);
         end
         if (win_q[i].valid && win_q[i].has_dest && win_q[i].dest == rb) begin
            hit_b = 1'b1;
            idx_b = IDX_W'(i);
         end
      end
   end

   assign use_a = hit_a && !flush && (ra != '0) && (opc == OPC_ADD || opc == OPC_SW);
   assign use_b = hit_b && !flush && (rb != '0) && (opc != OPC_NOOP);

   assign kind_a = (win_q[idx_a].is_load && idx_a == '0) ? KIND_LOAD_USE : KIND_RAW;
   assign kind_b = (win_q[idx_b].is_load && idx_b == '0) ? KIND_LOAD_USE : KIND_RAW;
   assign rec_a  = {win_q[idx_a].seq, seq_cnt_q, kind_a};
   assign rec_b  = {win_q[idx_b].seq, seq_cnt_q, kind_b};

`ifdef HDU_FWD_EN
   assign keep_a = (kind_a == KIND_LOAD_USE);
   assign keep_b = (kind_b == KIND_LOAD_USE);
`else
   assign keep_a = 1'b1;
   assign keep_b = 1'b1;
`endif

   assign en_a   = use_a && keep_a;
   assign en_b   = use_b && keep_b && !(use_a && idx_a == idx_b);
   assign wr0_en = accept && (en_a || en_b);
   assign wr1_en = accept && en_a && en_b;

   assign new_entry = '{valid:    1'b1,
                        has_dest: opc_writes(opc) && (ra != '0),
                        dest:     ra,
                        is_load:  (opc == OPC_LW),
                        seq:      seq_cnt_q};

   assign cnt_sum = {1'b0, cnt_q} + 17'(wr0_en) + 17'(wr1_en);
   assign cnt_d   = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) win_q[i] <= '0;
         seq_cnt_q <= '0;
         cnt_q     <= '0;
      end else begin
         if (accept) begin
            seq_cnt_q <= seq_cnt_q + SEQ_W'(1);
            win_q[0]  <= new_entry;
            for (int i = 1; i < int'(DEPTH); i++) begin
               win_q[i] <= win_q[i-1];
               if (flush) win_q[i].valid <= 1'b0;
            end
         end else if (flush) begin
            for (int i = 0; i < int'(DEPTH); i++) win_q[i].valid <= 1'b0;
         end
         cnt_q <= cnt_d;
      end
   end

   hdu_rec_fifo #(
      .WIDTH (REC_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr0_en   (wr0_en),
      .wr0_data (en_a ? rec_a : rec_b),
      .wr1_en   (wr1_en),
      .wr1_data (rec_b),
      .rd_en    (rec_ready),
      .rd_valid (rec_valid),
      .rd_data  (rec_data),
      .free     (free)
   );

   assign in_ready   = (free >= FREE_W'(2));
   assign hazard_cnt = cnt_q;

endmodule
